// File: rtl/tlc_pkg.sv
// Shared definitions for the two-road traffic light phase scheduler:
// state encodings, lamp patterns and default dwell durations.
package tlc_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_G1   = 3'd1,
        S_Y1   = 3'd2,
        S_AR1  = 3'd3,
        S_G2   = 3'd4,
        S_Y2   = 3'd5,
        S_AR2  = 3'd6
    } state_e;

    // Lamp vector bit order: {r1, y1, g1, r2, y2, g2}
    localparam logic [5:0] LAMP_ALLRED = 6'b100_100;
    localparam logic [5:0] LAMP_G1     = 6'b001_100;
    localparam logic [5:0] LAMP_Y1     = 6'b010_100;
    localparam logic [5:0] LAMP_G2     = 6'b100_001;
    localparam logic [5:0] LAMP_Y2     = 6'b100_010;

    localparam int DEF_MIN_G = 5;
    localparam int DEF_MAX_G = 20;
    localparam int DEF_YEL_T = 3;
    localparam int DEF_AR_T  = 1;
    localparam int DEF_CW    = 5;

    function automatic logic [5:0] lamps_of(input state_e s);
        case (s)
            S_G1:    lamps_of = LAMP_G1;
            S_Y1:    lamps_of = LAMP_Y1;
            S_G2:    lamps_of = LAMP_G2;
            S_Y2:    lamps_of = LAMP_Y2;
            default: lamps_of = LAMP_ALLRED;
        endcase
    endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Sensor/timebase inputs and lamp/status outputs of the phase scheduler.
// The scheduler is the slave side; whoever drives tick and sensors is master.
interface tlc_phase_scheduler_if;
    logic       tick;
    logic       x;
    logic       y;
    logic       r1, y1, g1;
    logic       r2, y2, g2;
    logic [2:0] phase;
    logic [1:0] req_pend;

    modport master (
        output tick, x, y,
        input  r1, y1, g1, r2, y2, g2, phase, req_pend
    );

    modport slave (
        input  tick, x, y,
        output r1, y1, g1, r2, y2, g2, phase, req_pend
    );
endinterface

// File: rtl/tlc_dwell_timer.sv
// Dwell counter: synchronous clear, advances on enable, holds at lim.
module tlc_dwell_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] lim,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != lim))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Two-road traffic light scheduler: rest-in-green with demand latching,
// minimum/maximum green, yellow and all-red clearance between greens.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_G = DEF_MIN_G,
    parameter int MAX_G = DEF_MAX_G,
    parameter int YEL_T = DEF_YEL_T,
    parameter int AR_T  = DEF_AR_T,
    parameter int CW    = DEF_CW
) (
    input  logic                  clk,
    input  logic                  reset,
    tlc_phase_scheduler_if.slave  bus
);

    localparam logic [CW-1:0] MIN_C = CW'(MIN_G - 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_G - 1);
    localparam logic [CW-1:0] YEL_C = CW'(YEL_T - 1);
    localparam logic [CW-1:0] AR_C  = CW'(AR_T - 1);

    state_e        state, next;
    logic [CW-1:0] cnt, lim;
    logic          clr;
    logic [1:0]    req_q, req_d;
    logic [5:0]    lamp_q;
    logic [2:0]    phase_q;

    tlc_dwell_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (bus.tick),
        .lim   (lim),
        .cnt   (cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= next;
    end

    // lim doubles as the exit threshold for timed states and the green cap.
    always_comb begin
        next = S_INIT;
        lim  = '0;
        case (state)
            S_INIT: begin
                lim  = AR_C;
                next = state;
                if (bus.tick && cnt == AR_C)
                    next = (req_q == 2'b10) ? S_G2 : S_G1;
            end
            S_G1: begin
                lim  = MAX_C;
                next = state;
                if (bus.tick && req_q[1] && cnt >= MIN_C && (!bus.x || cnt == MAX_C))
                    next = S_Y1;
            end
            S_Y1: begin
                lim  = YEL_C;
                next = state;
                if (bus.tick && cnt == YEL_C) next = S_AR1;
            end
            S_AR1: begin
                lim  = AR_C;
                next = state;
                if (bus.tick && cnt == AR_C) next = S_G2;
            end
            S_G2: begin
                lim  = MAX_C;
                next = state;
                if (bus.tick && req_q[0] && cnt >= MIN_C && (!bus.y || cnt == MAX_C))
                    next = S_Y2;
            end
            S_Y2: begin
                lim  = YEL_C;
                next = state;
                if (bus.tick && cnt == YEL_C) next = S_AR2;
            end
            S_AR2: begin
                lim  = AR_C;
                next = state;
                if (bus.tick && cnt == AR_C) next = S_G1;
            end
            default: next = S_INIT;
        endcase
        clr = (next != state);
    end

    // Demand latching ignores tick; clearing on green entry overrides a same-cycle set.
    always_comb begin
        req_d = req_q;
        if (bus.x && state != S_G1) req_d[0] = 1'b1;
        if (bus.y && state != S_G2) req_d[1] = 1'b1;
        if (next == S_G1 && state != S_G1) req_d[0] = 1'b0;
        if (next == S_G2 && state != S_G2) req_d[1] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= 2'b00;
            lamp_q  <= LAMP_ALLRED;
            phase_q <= S_INIT;
        end else begin
            req_q   <= req_d;
            lamp_q  <= lamps_of(next);
            phase_q <= next;
        end
    end

    assign {bus.r1, bus.y1, bus.g1, bus.r2, bus.y2, bus.g2} = lamp_q;
    assign bus.phase    = phase_q;
    assign bus.req_pend = req_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler with default durations
// (MIN_G=5, MAX_G=20, YEL_T=3, AR_T=1).
module tb_tlc_phase_scheduler;

    localparam logic [2:0] P_INIT = 3'd0, P_G1 = 3'd1, P_Y1 = 3'd2, P_AR1 = 3'd3,
                           P_G2 = 3'd4, P_Y2 = 3'd5, P_AR2 = 3'd6;

    logic clk;
    logic reset;
    tlc_phase_scheduler_if bus ();

    tlc_phase_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q[$];

    typedef struct {
        logic       tick;
        logic       x;
        logic       y;
        logic [2:0] ph;
        logic [5:0] lm;
        logic [1:0] rq;
    } vec_t;

    vec_t vt[20];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic xi, input logic yi);
        bus.tick = t;
        bus.x    = xi;
        bus.y    = yi;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] lamps_now();
        return {bus.r1, bus.y1, bus.g1, bus.r2, bus.y2, bus.g2};
    endfunction

    function automatic logic [5:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            P_G1:    return 6'b001_100;
            P_Y1:    return 6'b010_100;
            P_G2:    return 6'b100_001;
            P_Y2:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic check_state(input string nm, input logic [2:0] ph, input logic [1:0] rq);
        check({nm, ".phase"}, 32'(bus.phase), 32'(ph));
        check({nm, ".lamps"}, 32'(lamps_now()), 32'(exp_lamps(ph)));
        check({nm, ".req"},   32'(bus.req_pend), 32'(rq));
    endtask

    task automatic do_reset(input logic xi, input logic yi);
        drive(1'b0, xi, yi);
        reset = 1'b1;
        step();
        step();
        check_state("reset", P_INIT, 2'b00);
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic found;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        vt[0]  = '{1'b1, 1'b0, 1'b0, P_G1,  6'b001_100, 2'b00};
        vt[1]  = '{1'b1, 1'b0, 1'b1, P_G1,  6'b001_100, 2'b10};
        vt[2]  = '{1'b1, 1'b0, 1'b0, P_G1,  6'b001_100, 2'b10};
        vt[3]  = '{1'b1, 1'b0, 1'b0, P_G1,  6'b001_100, 2'b10};
        vt[4]  = '{1'b1, 1'b0, 1'b0, P_G1,  6'b001_100, 2'b10};
        vt[5]  = '{1'b1, 1'b0, 1'b0, P_Y1,  6'b010_100, 2'b10};
        vt[6]  = '{1'b1, 1'b0, 1'b0, P_Y1,  6'b010_100, 2'b10};
        vt[7]  = '{1'b1, 1'b0, 1'b0, P_Y1,  6'b010_100, 2'b10};
        vt[8]  = '{1'b1, 1'b0, 1'b0, P_AR1, 6'b100_100, 2'b10};
        vt[9]  = '{1'b1, 1'b0, 1'b0, P_G2,  6'b100_001, 2'b00};
        vt[10] = '{1'b1, 1'b0, 1'b0, P_G2,  6'b100_001, 2'b00};
        vt[11] = '{1'b0, 1'b1, 1'b0, P_G2,  6'b100_001, 2'b01};
        vt[12] = '{1'b1, 1'b0, 1'b0, P_G2,  6'b100_001, 2'b01};
        vt[13] = '{1'b1, 1'b0, 1'b0, P_G2,  6'b100_001, 2'b01};
        vt[14] = '{1'b1, 1'b0, 1'b0, P_G2,  6'b100_001, 2'b01};
        vt[15] = '{1'b1, 1'b0, 1'b0, P_Y2,  6'b100_010, 2'b01};
        vt[16] = '{1'b1, 1'b0, 1'b0, P_Y2,  6'b100_010, 2'b01};
        vt[17] = '{1'b1, 1'b0, 1'b0, P_Y2,  6'b100_010, 2'b01};
        vt[18] = '{1'b1, 1'b0, 1'b0, P_AR2, 6'b100_100, 2'b01};
        vt[19] = '{1'b1, 1'b0, 1'b0, P_G1,  6'b001_100, 2'b00};

        // Idle: one INIT tick then rest in G1 with no demand.
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            step();
            check_state($sformatf("idle[%0d]", i), P_G1, 2'b00);
        end

        // Full cycle G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [10:0] obs, exp;
            drive(vt[i].tick, vt[i].x, vt[i].y);
            exp_q.push_back({vt[i].ph, vt[i].lm, vt[i].rq});
            step();
            obs = {bus.phase, lamps_now(), bus.req_pend};
            exp = exp_q.pop_front();
            check($sformatf("vec[%0d]", i), 32'(obs), 32'(exp));
        end

        // Max green: x held with y pending, Y1 on the 20th tick of G1.
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 1'b1, (k == 1));
            step();
            if (k < 20) check_state($sformatf("maxg[%0d]", k), P_G1, 2'b10);
            else        check_state("maxg[20]", P_Y1, 2'b10);
        end
        drive(1'b1, 1'b0, 1'b0);

        // Reach Y2, advance to cnt=1, then assert reset between edges.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            drive(1'b1, (i == 0), 1'b0);
            step();
            if (bus.phase == P_Y2) found = 1'b1;
        end
        check("reach_y2", 32'(found), 32'd1);
        drive(1'b1, 1'b0, 1'b1);
        step();
        check("y2_cnt1.phase", 32'(bus.phase), 32'(P_Y2));
        #2;
        reset = 1'b1;
        #1;
        check_state("async_reset", P_INIT, 2'b00);
        step();
        check_state("async_reset_hold", P_INIT, 2'b00);

        // x and y both high from reset: alternate bounded by MAX_G, never both green.
        do_reset(1'b1, 1'b1);
        for (int e = 1; e <= 60; e++) begin
            drive(1'b1, 1'b1, 1'b1);
            step();
            check($sformatf("both[%0d].g1g2", e), 32'(bus.g1 & bus.g2), 32'd0);
            check($sformatf("both[%0d].road1", e), 32'($countones({bus.r1, bus.y1, bus.g1})), 32'd1);
            check($sformatf("both[%0d].road2", e), 32'($countones({bus.r2, bus.y2, bus.g2})), 32'd1);
            case (e)
                1, 20:  check($sformatf("both[%0d].ph", e), 32'(bus.phase), 32'(P_G1));
                21:     check("both[21].ph", 32'(bus.phase), 32'(P_Y1));
                24:     check("both[24].ph", 32'(bus.phase), 32'(P_AR1));
                25, 44: check($sformatf("both[%0d].ph", e), 32'(bus.phase), 32'(P_G2));
                45:     check("both[45].ph", 32'(bus.phase), 32'(P_Y2));
                48:     check("both[48].ph", 32'(bus.phase), 32'(P_AR2));
                49:     check("both[49].ph", 32'(bus.phase), 32'(P_G1));
                default: ;
            endcase
        end

        // Tick every 4th cycle; y pulse on a non-tick cycle still latches.
        do_reset(1'b0, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            drive((c % 4 == 0), 1'b0, (c == 5));
            step();
            case (c)
                3:       check_state("slow[3]",  P_INIT, 2'b00);
                4:       check_state("slow[4]",  P_G1,   2'b00);
                5:       check_state("slow[5]",  P_G1,   2'b10);
                23:      check_state("slow[23]", P_G1,   2'b10);
                24:      check_state("slow[24]", P_Y1,   2'b10);
                35:      check_state("slow[35]", P_Y1,   2'b10);
                36:      check_state("slow[36]", P_AR1,  2'b10);
                39:      check_state("slow[39]", P_AR1,  2'b10);
                40:      check_state("slow[40]", P_G2,   2'b00);
                default: ;
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlc_phase_scheduler.md
TLC_PHASE_SCHEDULER -- requirements
Module: tlc_phase_scheduler

Interface
REQ-001 Parameter MIN_G, default 5, minimum green dwell in ticks (>=1).
REQ-002 Parameter MAX_G, default 20, maximum green dwell in ticks when opposing demand exists (>= MIN_G).
REQ-003 Parameter YEL_T, default 3, yellow dwell in ticks (>=1).
REQ-004 Parameter AR_T, default 1, all-red clearance dwell in ticks (>=1).
REQ-005 Parameter CW, default 5, dwell counter width; 2^CW shall exceed MAX_G.
REQ-006 clk  input  1  system clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 tick  input  1  one-cycle timebase strobe; all dwell counting advances only on cycles with tick=1.
REQ-009 x  input  1  road-1 vehicle sensor, level, synchronous to clk.
REQ-010 y  input  1  road-2 vehicle sensor, level, synchronous to clk.
REQ-011 r1,y1,g1  output  1 each  road-1 lamps, registered, exactly one high at all times.
REQ-012 r2,y2,g2  output  1 each  road-2 lamps, registered, exactly one high at all times.
REQ-013 phase  output  3  current state encoding (package constant), registered.
REQ-014 req_pend  output  2  latched demand, bit0 road 1, bit1 road 2.

Function
REQ-015 States: INIT, G1, Y1, AR1, G2, Y2, AR2; lamps: INIT/AR1/AR2 r1=r2=1; G1 g1,r2; Y1 y1,r2; G2 r1,g2; Y2 r1,y2.
REQ-016 Dwell counter cnt clears to 0 on every state entry; increments on tick; saturates at MAX_G-1 in G1/G2.
REQ-017 A timed state with duration D exits on the clock edge where tick=1 and cnt==D-1, giving exactly D ticks of dwell.
REQ-018 INIT (duration AR_T) exits to G2 if req_pend==2'b10, else to G1.
REQ-019 G1 exits to Y1 on tick when req_pend[1]=1 and cnt>=MIN_G-1 and (x==0 or cnt==MAX_G-1); otherwise G1 holds (rest-in-green with no opposing demand, unbounded).
REQ-020 G2 exits to Y2 symmetrically using req_pend[0] and y.
REQ-021 Y1 (YEL_T) -> AR1 (AR_T) -> G2; Y2 (YEL_T) -> AR2 (AR_T) -> G1; never green-to-green without yellow and all-red.
REQ-022 req_pend[0] sets on any cycle x=1 while not in G1; req_pend[1] sets on any cycle y=1 while not in G2.
REQ-023 req_pend[n] clears on the edge entering that road's green; clear wins over a simultaneous set.
REQ-024 tick=0 cycles freeze cnt and state; sensor latching continues regardless of tick.
REQ-025 Lamps and phase update on the same edge as the state register (decoded from next state), no glitch, no one-cycle lag.
REQ-026 Unreachable state encodings recover to INIT on the next edge.

Reset
REQ-027 While reset=1: state INIT, cnt 0, req_pend 2'b00, r1=r2=1, y1=g1=y2=g2=0, phase=INIT.
REQ-028 Reset asserted mid-phase (including yellow) forces all-red immediately, asynchronously; after release, INIT runs full AR_T ticks.

Structure
REQ-029 Package tlc_pkg shall hold state encodings (3-bit), lamp-vector constants, and default durations.
REQ-030 One sub-module tlc_dwell_timer (clear, tick enable, saturating CW-bit count, cnt output) shall be instantiated once.

Verification
REQ-031 Reset release, no sensors, tick every cycle -> INIT 1 tick, then G1 held indefinitely, req_pend=00.
REQ-032 In G1 at cnt=0, pulse y one cycle, x=0 -> Y1 entered at tick 5, AR1 at tick 8, G2 at tick 9, req_pend[1] cleared on G2 entry.
REQ-033 In G1 with x=1 held and y pending -> green extends to MAX_G: Y1 entered exactly on 20th tick.
REQ-034 x and y both high from reset -> INIT->G1; lamps alternate G1/G2 every MIN_G+YEL_T+AR_T... bounded by MAX_G; never both green.
REQ-035 Assert reset during Y2 at cnt=1 -> lamps r1=r2=1 before next clk edge; req_pend=00.
REQ-036 tick asserted every 4th cycle -> all dwells scale by 4 cycles; y pulse on tick=0 cycle still latched.
